// File: rtl/ultrasonic_scan_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : ultrasonic_scan_scheduler
// Purpose  : Fires three ultrasonic rangers in turn (left, front, right), times
//            each echo in whole centimetres and publishes one coherent frame.
// Revision : 1.0 - initial release
// ============================================================================
module ultrasonic_scan_scheduler #(
  parameter int TRIG_CYCLES    = 500,
  parameter int CYCLES_PER_CM  = 2900,
  parameter int TIMEOUT_CYCLES = 1_500_000,
  parameter int GAP_CYCLES     = 500_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [2:0]  echo,
  output logic [2:0]  trig,
  output logic [15:0] dist_left,
  output logic [15:0] dist_front,
  output logic [15:0] dist_right,
  output logic [2:0]  timeout_flags,
  output logic        frame_valid,
  output logic        busy
);

  localparam int c_ph_max = (TRIG_CYCLES > GAP_CYCLES) ? TRIG_CYCLES : GAP_CYCLES;
  localparam int c_ph_w   = $clog2(c_ph_max + 1);
  localparam int c_tmo_w  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int c_ps_w   = $clog2(CYCLES_PER_CM + 1);

  localparam logic [c_ph_w-1:0]  c_trig_last = c_ph_w'(TRIG_CYCLES - 1);
  localparam logic [c_ph_w-1:0]  c_gap_last  = c_ph_w'(GAP_CYCLES - 1);
  localparam logic [c_tmo_w-1:0] c_tmo_last  = c_tmo_w'(TIMEOUT_CYCLES - 1);
  localparam logic [c_ps_w-1:0]  c_ps_last   = c_ps_w'(CYCLES_PER_CM - 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_TRIG      = 3'd1,
    ST_WAIT_RISE = 3'd2,
    ST_MEASURE   = 3'd3,
    ST_GAP       = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_state_nx;
  logic [1:0]          r_sel;
  logic [1:0]          w_sel_nx;
  logic [c_ph_w-1:0]   r_phase;
  logic [c_ph_w-1:0]   w_phase_nx;
  logic [c_tmo_w-1:0]  r_tmo;
  logic [c_tmo_w-1:0]  w_tmo_nx;
  logic [c_ps_w-1:0]   r_ps;
  logic [c_ps_w-1:0]   w_ps_nx;
  logic [15:0]         r_cm;
  logic [15:0]         w_cm_nx;
  logic [15:0]         w_cm_inc;
  logic [2:0][15:0]    r_shadow;
  logic [2:0][15:0]    w_shadow_nx;
  logic [2:0]          r_shadow_tmo;
  logic [2:0]          w_shadow_tmo_nx;
  logic                w_publish;
  logic                w_tmo_hit;
  logic                w_echo;

  logic [2:0]          r_echo_meta;
  logic [2:0]          r_echo_sync;
  logic [15:0]         r_dist_left;
  logic [15:0]         r_dist_front;
  logic [15:0]         r_dist_right;
  logic [2:0]          r_flags;
  logic                r_frame_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_echo_meta <= 3'b000;
      r_echo_sync <= 3'b000;
    end else begin
      r_echo_meta <= echo;
      r_echo_sync <= r_echo_meta;
    end
  end

  assign w_echo = r_echo_sync[r_sel];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_sel        <= 2'd0;
      r_phase      <= '0;
      r_tmo        <= '0;
      r_ps         <= '0;
      r_cm         <= 16'd0;
      r_shadow     <= '0;
      r_shadow_tmo <= 3'b000;
    end else begin
      r_state      <= w_state_nx;
      r_sel        <= w_sel_nx;
      r_phase      <= w_phase_nx;
      r_tmo        <= w_tmo_nx;
      r_ps         <= w_ps_nx;
      r_cm         <= w_cm_nx;
      r_shadow     <= w_shadow_nx;
      r_shadow_tmo <= w_shadow_tmo_nx;
    end
  end

  always_comb begin
    w_state_nx      = r_state;
    w_sel_nx        = r_sel;
    w_phase_nx      = r_phase;
    w_tmo_nx        = r_tmo;
    w_ps_nx         = r_ps;
    w_cm_nx         = r_cm;
    w_shadow_nx     = r_shadow;
    w_shadow_tmo_nx = r_shadow_tmo;
    w_publish       = 1'b0;
    w_cm_inc        = (r_cm == 16'hFFFF) ? r_cm : r_cm + 16'd1;
    w_tmo_hit       = (r_tmo == c_tmo_last);

    case (r_state)
      ST_IDLE: begin
        w_sel_nx   = 2'd0;
        w_phase_nx = '0;
        w_tmo_nx   = '0;
        w_ps_nx    = '0;
        w_cm_nx    = 16'd0;
        if (enable) begin
          w_state_nx = ST_TRIG;
        end
      end

      ST_TRIG: begin
        if (r_phase == c_trig_last) begin
          w_state_nx = ST_WAIT_RISE;
          w_phase_nx = '0;
          w_tmo_nx   = '0;
        end else begin
          w_phase_nx = r_phase + 1'b1;
        end
      end

      ST_WAIT_RISE: begin
        w_tmo_nx = r_tmo + 1'b1;
        if (w_tmo_hit) begin
          w_shadow_nx[r_sel]     = 16'd0;
          w_shadow_tmo_nx[r_sel] = 1'b1;
          w_state_nx             = ST_GAP;
          w_phase_nx             = '0;
        end else if (w_echo) begin
          w_state_nx = ST_MEASURE;
          w_ps_nx    = '0;
          w_cm_nx    = 16'd0;
        end
      end

      ST_MEASURE: begin
        w_tmo_nx = r_tmo + 1'b1;
        if (r_ps == c_ps_last) begin
          w_ps_nx = '0;
          w_cm_nx = w_cm_inc;
        end else begin
          w_ps_nx = r_ps + 1'b1;
        end
        // Timeout wins over a simultaneous echo fall.
        if (w_tmo_hit) begin
          w_shadow_nx[r_sel]     = 16'd0;
          w_shadow_tmo_nx[r_sel] = 1'b1;
          w_state_nx             = ST_GAP;
          w_phase_nx             = '0;
        end else if (!w_echo) begin
          w_shadow_nx[r_sel]     = w_cm_nx;
          w_shadow_tmo_nx[r_sel] = 1'b0;
          w_state_nx             = ST_GAP;
          w_phase_nx             = '0;
        end
      end

      ST_GAP: begin
        if (r_phase == c_gap_last) begin
          w_phase_nx = '0;
          if (r_sel == 2'd2) begin
            w_state_nx = ST_IDLE;
          end else begin
            w_sel_nx   = r_sel + 2'd1;
            w_state_nx = ST_TRIG;
          end
        end else begin
          w_phase_nx = r_phase + 1'b1;
        end
      end

      default: begin
        w_state_nx = ST_IDLE;
      end
    endcase

    // Load the outputs so they appear during the final GAP cycle, keeping busy high.
    w_publish = (w_state_nx == ST_GAP) && (w_sel_nx == 2'd2) && (w_phase_nx == c_gap_last);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dist_left   <= 16'd0;
      r_dist_front  <= 16'd0;
      r_dist_right  <= 16'd0;
      r_flags       <= 3'b000;
      r_frame_valid <= 1'b0;
    end else begin
      r_frame_valid <= w_publish;
      if (w_publish) begin
        r_dist_left  <= w_shadow_nx[0];
        r_dist_front <= w_shadow_nx[1];
        r_dist_right <= w_shadow_nx[2];
        r_flags      <= w_shadow_tmo_nx;
      end
    end
  end

  // Decoded from the state register so reset removes the trigger at once.
  assign trig          = (r_state == ST_TRIG) ? (3'b001 << r_sel) : 3'b000;
  assign busy          = (r_state != ST_IDLE);
  assign dist_left     = r_dist_left;
  assign dist_front    = r_dist_front;
  assign dist_right    = r_dist_right;
  assign timeout_flags = r_flags;
  assign frame_valid   = r_frame_valid;

endmodule
`default_nettype wire

// File: doc/ultrasonic_scan_scheduler.md
# ultrasonic_scan_scheduler

Sequences three HC-SR04-style ultrasonic rangers (left, front, right), one at a time, so their echoes cannot cross-talk. Each echo pulse is timed and converted to whole centimetres. The block publishes a coherent set of three 16-bit distances to `wall_follower_logic` once per scan frame. A reading of 0 means "no echo / timeout", which matches the wall follower's no-reading convention.

## Interface
Parameters:
- `TRIG_CYCLES`, default 500: trigger pulse width in clk cycles (10 µs at 50 MHz).
- `CYCLES_PER_CM`, default 2900: echo-high clk cycles per 1 cm (58 µs at 50 MHz).
- `TIMEOUT_CYCLES`, default 1_500_000: maximum cycles from trigger end to echo fall (30 ms).
- `GAP_CYCLES`, default 500_000: settle time after each sensor before the next trigger (10 ms).

Ports:
- `clk`  in  1  system clock; one clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  allows scanning; sampled only in IDLE.
- `echo`  in  3  raw asynchronous echo lines; bit0 left, bit1 front, bit2 right.
- `trig`  out  3  trigger outputs, same bit mapping; at most one bit high at any time.
- `dist_left`  out  16  published left distance, cm.
- `dist_front`  out  16  published front distance, cm.
- `dist_right`  out  16  published right distance, cm.
- `timeout_flags`  out  3  per-sensor timeout status for the last published frame.
- `frame_valid`  out  1  one-cycle pulse when the `dist_*` outputs and `timeout_flags` update.
- `busy`  out  1  high in every state except IDLE.

## Operation
- Each `echo` bit passes through a 2-flop synchronizer. All decisions use the synchronized level.
- Sensor index `sel` steps 0 → 1 → 2 within a frame, in the order left, front, right.
- The state machine has five states:
  - IDLE: `sel` = 0; the timeout counter, prescaler and cm counter are cleared. If `enable` = 1, go to TRIG on the next cycle; otherwise stay in IDLE.
  - TRIG: `trig[sel]` = 1 for exactly `TRIG_CYCLES` cycles, then go to WAIT_RISE. The timeout counter is cleared on entry to WAIT_RISE.
  - WAIT_RISE: the timeout counter increments every cycle. When synchronized `echo[sel]` = 1, go to MEASURE, clearing the prescaler and cm counter. The check is level-based: an echo that is already high counts as a rise.
  - MEASURE: the timeout counter keeps running. The prescaler increments every cycle; when it reaches `CYCLES_PER_CM`-1 it wraps to 0 and the cm counter increments, saturating at 16'hFFFF. When synchronized `echo[sel]` = 0, the cm counter is written to `shadow[sel]`, the timeout bit for `sel` is cleared in the shadow copy, and the machine goes to GAP.
  - Timeout (from WAIT_RISE or MEASURE): when the timeout counter reaches `TIMEOUT_CYCLES`, write 0 to `shadow[sel]`, set the shadow timeout bit for `sel`, and go to GAP.
  - GAP: wait `GAP_CYCLES` cycles with all `trig` = 0.
    - If `sel` < 2: increment `sel` and go to TRIG.
    - If `sel` = 2: copy all three shadows and the shadow flags to the outputs, pulse `frame_valid`, and go to IDLE.
- A partial cm is truncated: an echo high for N cycles yields floor(N / `CYCLES_PER_CM`) cm.
- If both exit conditions hold in the same cycle, timeout has priority over echo fall.
- Deasserting `enable` mid-frame does not abort the frame. The frame completes and publishes, then the block stays in IDLE.
- The outputs only change at frame publication. The wall follower never sees a mix of old and new readings.

## Timing
- Reset values: `trig` = 0, all `dist_*` = 0, `timeout_flags` = 0, `frame_valid` = 0, `busy` = 0, state IDLE, shadows 0.
- Reset asserted mid-frame: `trig` drops immediately (asynchronously) and all of the above reset values apply. After release, scanning starts from left.
- Echo path latency is 2 cycles through the synchronizer. The measured width equals the raw echo-high width.
- `trig[sel]` rises 1 cycle after IDLE sees `enable` = 1, or 1 cycle after the previous GAP ends.
- `frame_valid` is asserted in the same cycle the outputs take their new values, and is high for 1 cycle only.
- `busy` falls in the cycle after the `frame_valid` pulse. With `enable` held at 1, consecutive frames are separated by exactly 1 IDLE cycle.
- All counters are sized to hold their parameter value. The cm counter never wraps.

## Test plan
Unless stated otherwise, parameters are `TRIG_CYCLES`=4, `CYCLES_PER_CM`=10, `TIMEOUT_CYCLES`=1000, `GAP_CYCLES`=20.
- Reset: hold `rst_n` = 0, drive random `echo`, pulse `enable` → all outputs 0, no `trig`. After release with `enable` = 0, `busy` stays 0.
- Nominal frame: each echo answers 30 cycles after its trigger falls, with widths 150, 250 and 400 cycles → `dist_left`=15, `dist_front`=25, `dist_right`=40, `timeout_flags`=3'b000, exactly one `frame_valid`. Each `trig` is 4 cycles wide, and the triggers are one-hot and ordered left, front, right.
- Timeout: the front echo never rises → `dist_front`=0 and `timeout_flags`=3'b010. Left and right read correctly. The GAP before the right trigger starts 1000 cycles after the front trigger falls.
- Truncation and saturation:
  - Echo widths of 9, 10 and 19 cycles → 0, 1 and 1 cm.
  - With `TIMEOUT_CYCLES` raised to 2^22 and `CYCLES_PER_CM`=1, a 70000-cycle echo → 16'hFFFF.
- Enable dropped during front MEASURE → the frame completes and publishes, then `busy` = 0 and no further `trig` pulses appear.
- Reset during left MEASURE → `trig` = 0 immediately and outputs 0. After release with `enable` = 1, a clean frame restarts from left with correct values.
